control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Parametrised multicycle control unit; successor to the fixed 4-step control sequencer.
- Drives fetch, register read, ALU operand select, memory access and writeback for the RV32I base opcode classes.
- Adds a variable-length step sequence, a memory ready/wait handshake with optional timeout fault, and sticky halt/illegal states.
- Sits between the instruction register/decoder and the datapath (PC, register file, ALU, memory port).

Parameters:
- ENABLE_MEM, 1, 1 = LOAD/STORE supported; 0 = LOAD/STORE are illegal.
- MEM_TIMEOUT, 0, max cycles spent waiting in MEM; 0 = wait forever; otherwise 1..255.
- STATE_W, 3, width of the state output (fixed encoding below; must be >= 3).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward.
- branch_taken  in  1  ALU compare result; sampled in EXECUTE for BRANCH.
- mem_ready  in  1  memory completes the access this cycle.
- state  out  STATE_W  current state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5.
- ir_load  out  1  latch the fetched instruction.
- pc_enable  out  1  PC update strobe.
- pc_sel  out  1  0 = PC+4; 1 = ALU result (jump/branch target).
- reg_re1, reg_re2  out  1  register file read enables.
- reg_we  out  1  register file write enable.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
- alu_sel1  out  1  0 = rs1; 1 = PC.
- alu_sel2  out  1  0 = rs2; 1 = immediate.
- mem_re, mem_we  out  1  memory read/write request.
- halt  out  1  sticky; high while in HALT.
- illegal  out  1  sticky; unknown opcode seen.
- mem_fault  out  1  sticky; MEM_TIMEOUT expired.

Behaviour:
- Opcode classes: OP_IMM=0010011, OP=0110011, LUI=0110111, AUIPC=0010111, JAL=1101111, JALR=1100111, BRANCH=1100011, LOAD=0000011, STORE=0100011, SYSTEM=1110011. Every other value is illegal.
- Reset: state=FETCH; illegal, mem_fault and the timeout counter cleared. Reset mid-MEM aborts the access: mem_re/mem_we are low in the cycle after reset is asserted. Reset overrides every other event, including leaving HALT.
- All outputs are combinational decodes of state and opcode. The reset-state value of every strobe is 0, except ir_load=1 (FETCH).

Per-state actions and transitions:
- FETCH: ir_load=1. Next state is DECODE.
- DECODE: reg_re1=reg_re2=1.
  - SYSTEM: go to HALT.
  - Illegal opcode: set illegal, go to HALT.
  - Otherwise: go to EXECUTE.
- EXECUTE operand selects (all other classes use the 0 defaults):
  - alu_sel2=1 for OP_IMM, LUI, JALR, LOAD, STORE.
  - alu_sel1=1, alu_sel2=1 for AUIPC, JAL, BRANCH.
- EXECUTE transitions:
  - LOAD/STORE: go to MEM.
  - BRANCH: pc_enable=1; pc_sel=branch_taken; go to FETCH.
  - Otherwise: go to WRITEBACK.
- MEM: mem_re=1 for LOAD, mem_we=1 for STORE; requests are held until mem_ready.
  - mem_ready=1: LOAD goes to WRITEBACK. STORE sets pc_enable=1, pc_sel=0 and goes to FETCH.
  - Timeout counter increments each MEM cycle without mem_ready. When MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT without ready: set mem_fault, go to HALT.
  - mem_ready on the same cycle the count would expire: ready wins, no fault.
  - Counter clears on leaving MEM.
- WRITEBACK: reg_we=1; pc_enable=1.
  - pc_sel=1 for JAL/JALR, else 0.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 for all others.
  - Next state is FETCH.
- HALT: absorbing until reset. All strobes 0; halt=1; pc_enable never asserts.

Latency (cycles per instruction):
- OP/OP_IMM/LUI/AUIPC/JAL/JALR: 4.
- BRANCH: 3.
- LOAD: 5+w; STORE: 4+w, where w = cycles with mem_ready low.
- Opcode is sampled continuously from DECODE to retire; the instruction register must hold it stable.

Test Plan:
- Reset, then ADDI (0010011) → states 0,1,2,4,0. reg_we=1 and pc_enable=1 only in cycle 4 (WRITEBACK), with alu_sel2=1.
- BEQ (1100011) with branch_taken=1 → pc_enable=1 and pc_sel=1 in EXECUTE; back in FETCH at cycle 4. Repeat with taken=0 → pc_sel=0.
- LOAD with mem_ready low for 3 cycles → mem_re high for 4 MEM cycles, then WRITEBACK with wb_sel=1. Total 8 cycles.
- MEM_TIMEOUT=4, STORE, mem_ready never asserted → mem_fault=1 and state=5 after 4 MEM cycles; mem_we low thereafter. With ready on the 4th cycle: no fault.
- Opcode 1111111 → illegal=1, halt=1 after DECODE. ECALL (1110011) → halt=1, illegal=0. Both stay halted for 20 cycles, then reset returns to FETCH with flags cleared.
- Reset asserted during the MEM wait of a LOAD → next cycle state=0, mem_re=0, reg_we never asserted.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm: multicycle RV32I control unit with memory wait/timeout and sticky halt/illegal states
module control_fsm #(
    parameter int ENABLE_MEM  = 1,
    parameter int MEM_TIMEOUT = 0,
    parameter int STATE_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               branch_taken,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state,
    output logic               ir_load,
    output logic               pc_enable,
    output logic               pc_sel,
    output logic               reg_re1,
    output logic               reg_re2,
    output logic               reg_we,
    output logic [1:0]         wb_sel,
    output logic               alu_sel1,
    output logic               alu_sel2,
    output logic               mem_re,
    output logic               mem_we,
    output logic               halt,
    output logic               illegal,
    output logic               mem_fault
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    logic       r_illegal;
    logic       r_fault;
    logic [7:0] r_cnt;

    logic w_op_imm, w_op, w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store, w_sys;
    logic w_legal, w_mem, w_link, w_timeout;
    logic w_fetch, w_decode, w_exec, w_in_mem, w_wb;

    assign w_op_imm  = opcode == 7'b0010011;
    assign w_op      = opcode == 7'b0110011;
    assign w_lui     = opcode == 7'b0110111;
    assign w_auipc   = opcode == 7'b0010111;
    assign w_jal     = opcode == 7'b1101111;
    assign w_jalr    = opcode == 7'b1100111;
    assign w_branch  = opcode == 7'b1100011;
    assign w_load    = (opcode == 7'b0000011) && (ENABLE_MEM != 0);
    assign w_store   = (opcode == 7'b0100011) && (ENABLE_MEM != 0);
    assign w_sys     = opcode == 7'b1110011;
    assign w_legal   = w_op_imm | w_op | w_lui | w_auipc | w_jal | w_jalr | w_branch | w_load | w_store | w_sys;
    assign w_mem     = w_load | w_store;
    assign w_link    = w_jal | w_jalr;

    assign w_fetch   = r_state == S_FETCH;
    assign w_decode  = r_state == S_DECODE;
    assign w_exec    = r_state == S_EXEC;
    assign w_in_mem  = r_state == S_MEM;
    assign w_wb      = r_state == S_WB;

    // ready in the final allowed cycle beats the timeout
    assign w_timeout = (MEM_TIMEOUT != 0) && w_in_mem && !mem_ready && (r_cnt == LP_LAST);

    // state sequencing, sticky fault flags and MEM wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
            r_cnt     <= 8'd0;
        end else begin
            r_cnt <= (w_in_mem && !mem_ready && !w_timeout) ? r_cnt + 8'd1 : 8'd0;
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_legal) r_illegal <= 1'b1;
                    r_state <= (w_sys || !w_legal) ? S_HALT : S_EXEC;
                end
                S_EXEC: r_state <= w_mem ? S_MEM : w_branch ? S_FETCH : S_WB;
                S_MEM: begin
                    if (w_timeout) r_fault <= 1'b1;
                    r_state <= mem_ready ? (w_load ? S_WB : S_FETCH) : w_timeout ? S_HALT : S_MEM;
                end
                S_WB: r_state <= S_FETCH;
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign state     = STATE_W'(r_state);
    assign ir_load   = w_fetch;
    assign reg_re1   = w_decode;
    assign reg_re2   = w_decode;
    assign alu_sel1  = w_exec & (w_auipc | w_jal | w_branch);
    assign alu_sel2  = w_exec & (w_op_imm | w_lui | w_jalr | w_load | w_store | w_auipc | w_jal | w_branch);
    assign pc_enable = (w_exec & w_branch) | (w_in_mem & w_store & mem_ready) | w_wb;
    assign pc_sel    = (w_exec & w_branch & branch_taken) | (w_wb & w_link);
    assign mem_re    = w_in_mem & w_load;
    assign mem_we    = w_in_mem & w_store;
    assign reg_we    = w_wb;
    assign wb_sel    = !w_wb ? 2'd0 : w_load ? 2'd1 : w_link ? 2'd2 : 2'd0;
    assign halt      = r_state == S_HALT;
    assign illegal   = r_illegal;
    assign mem_fault = r_fault;
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench for control_fsm with a per-instruction reference model
module tb_control_fsm;
    localparam int TO = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       ir, pce, pcs, r1, r2, we;
        logic [1:0] wbs;
        logic       a1, a2, mre, mwe, hlt, ill, flt;
    } out_t;

    logic       clk, reset, branch_taken, mem_ready;
    logic [6:0] opcode;
    logic [2:0] state;
    logic       ir_load, pc_enable, pc_sel, reg_re1, reg_re2, reg_we;
    logic [1:0] wb_sel;
    logic       alu_sel1, alu_sel2, mem_re, mem_we, halt, illegal, mem_fault;

    control_fsm #(.ENABLE_MEM(1), .MEM_TIMEOUT(TO), .STATE_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .state(state), .ir_load(ir_load), .pc_enable(pc_enable), .pc_sel(pc_sel),
        .reg_re1(reg_re1), .reg_re2(reg_re2), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_sel1(alu_sel1), .alu_sel2(alu_sel2), .mem_re(mem_re), .mem_we(mem_we),
        .halt(halt), .illegal(illegal), .mem_fault(mem_fault)
    );

    localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011, LUI = 7'b0110111, AUI = 7'b0010111,
                           JAL = 7'b1101111, JLR = 7'b1100111, BRA = 7'b1100011, LD = 7'b0000011,
                           ST = 7'b0100011, SYS = 7'b1110011;
    logic [6:0] ops [0:9];

    out_t act, m_e;
    out_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   m_halt, m_ill, m_flt;

    assign act = '{st: state, ir: ir_load, pce: pc_enable, pcs: pc_sel, r1: reg_re1, r2: reg_re2,
                   we: reg_we, wbs: wb_sel, a1: alu_sel1, a2: alu_sel2, mre: mem_re, mwe: mem_we,
                   hlt: halt, ill: illegal, flt: mem_fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: one expected output vector per checked cycle, compared mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            checks++;
            if (act !== m_e) begin
                errors++;
                $display("FAIL outputs[st=%0d] t=%0t got=%b exp=%b", m_e.st, $time, act, m_e);
            end
        end
    end

    function automatic bit is_legal(input logic [6:0] o);
        foreach (ops[i]) if (o == ops[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic out_t base(input int st);
        out_t o = '0;
        o.st  = 3'(st);
        o.hlt = (st == 5);
        o.ill = m_ill;
        o.flt = m_flt;
        return o;
    endfunction

    task automatic rnd_in();
        branch_taken = 1'($urandom);
        mem_ready    = 1'($urandom);
    endtask

    task automatic step(input out_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rnd_in();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_halt = 0;
        m_ill  = 0;
        m_flt  = 0;
    endtask

    // reference model: expected cycle sequence for one instruction, derived from the opcode class
    task automatic run_instr(input logic [6:0] op, input int waits, input int tk, input int rst_k);
        out_t e;
        bit   ld, sto, lnk;
        ld  = (op == LD);
        sto = (op == ST);
        lnk = (op == JAL) || (op == JLR);
        opcode = op;
        if (m_halt) begin
            repeat (2) begin rnd_in(); step(base(5)); end
            return;
        end
        rnd_in(); e = base(0); e.ir = 1; step(e);
        rnd_in(); e = base(1); e.r1 = 1; e.r2 = 1; step(e);
        if (op == SYS || !is_legal(op)) begin
            if (op != SYS) m_ill = 1;
            m_halt = 1;
            rnd_in(); step(base(5));
            return;
        end
        rnd_in();
        if (tk >= 0) branch_taken = tk[0];
        e = base(2);
        e.a1 = (op == AUI) || (op == JAL) || (op == BRA);
        e.a2 = (op != OPR);
        if (op == BRA) begin
            e.pce = 1; e.pcs = branch_taken; step(e);
            return;
        end
        step(e);
        if (ld || sto) begin
            for (int k = 0; k < 300; k++) begin
                rnd_in();
                mem_ready = (k == waits);
                if (k == rst_k) begin
                    mem_ready = 1'b0;
                    do_reset();
                    return;
                end
                e = base(3); e.mre = ld; e.mwe = sto; e.pce = sto && mem_ready;
                step(e);
                if (mem_ready) break;
                if (k + 1 == TO) begin
                    m_flt = 1; m_halt = 1;
                    rnd_in(); step(base(5));
                    return;
                end
            end
            if (sto) return;
        end
        rnd_in();
        e = base(4); e.we = 1; e.pce = 1; e.pcs = lnk; e.wbs = ld ? 2'd1 : lnk ? 2'd2 : 2'd0;
        step(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        ops = '{OPI, OPR, LUI, AUI, JAL, JLR, BRA, LD, ST, SYS};
        reset = 1'b1; opcode = 7'd0; branch_taken = 1'b0; mem_ready = 1'b0;
        m_halt = 0; m_ill = 0; m_flt = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(OPI, 0, -1, -1);
        run_instr(BRA, 0, 1, -1);
        run_instr(BRA, 0, 0, -1);
        run_instr(LD, 3, -1, -1);
        run_instr(ST, 99, -1, -1);
        run_instr(ST, 0, -1, -1);
        do_reset();
        run_instr(ST, 3, -1, -1);
        run_instr(7'b1111111, 0, -1, -1);
        repeat (10) run_instr(OPI, 0, -1, -1);
        do_reset();
        run_instr(SYS, 0, -1, -1);
        repeat (10) run_instr(OPI, 0, -1, -1);
        do_reset();
        run_instr(LD, 5, -1, 2);
        run_instr(JAL, 0, -1, -1);
        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            run_instr(op, $urandom_range(0, 5), -1, ($urandom_range(0, 15) == 0) ? 1 : -1);
            if (m_halt) begin
                run_instr(op, 0, -1, -1);
                do_reset();
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard-drain left=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
